// File: rtl/score_bcd_keeper_if.sv
// Award-event inputs and score outputs of the score keeper.
// The master side drives events and clear; the slave side returns score and status.
interface score_bcd_keeper_if;
    logic        clr;
    logic        pellet_evt;
    logic        power_evt;
    logic        ghost_evt;
    logic        combo_rst;
    logic [15:0] score;
    logic [1:0]  ghost_mult;
    logic        busy;
    logic        saturated;

    modport master (
        output clr, pellet_evt, power_evt, ghost_evt, combo_rst,
        input  score, ghost_mult, busy, saturated
    );

    modport slave (
        input  clr, pellet_evt, power_evt, ghost_evt, combo_rst,
        output score, ghost_mult, busy, saturated
    );
endinterface

// File: rtl/score_bcd_keeper.sv
// Purpose: 4-digit packed-BCD score, awards queued per type and added one digit per cycle.
// Latency: event at edge E -> pick at E+1 -> score commits at E+5; one award per 5 cycles.
// Backpressure: none; each pending counter saturates and drops further pulses.
module score_bcd_keeper #(
    parameter logic [15:0] PELLET_PTS = 16'h0010,
    parameter logic [15:0] POWER_PTS  = 16'h0050,
    parameter int          PEND_W     = 4
) (
    input logic               clk,
    input logic               rst,
    score_bcd_keeper_if.slave bus
);
    typedef enum logic {IDLE, ADD} state_t;

    state_t            state, state_nxt;
    logic [PEND_W-1:0] pend_pel, pend_pow, pend_gho;
    logic              pick_pel, pick_pow, pick_gho, pick_any;
    logic              any_pend;
    logic [15:0]       acc, addend, addend_sel, score_q;
    logic [1:0]        idx, mult;
    logic              carry, sat;
    logic [4:0]        dsum, dsum_adj;
    logic [3:0]        dig;
    logic              dcarry;

    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                    input logic evt, input logic pick);
        logic [PEND_W-1:0] r;
        r = cnt;
        if (evt && !pick && !(&cnt))
            r = cnt + PEND_W'(1);
        else if (pick && !evt)
            r = cnt - PEND_W'(1);
        return r;
    endfunction

    assign any_pend = (pend_pel != '0) || (pend_pow != '0) || (pend_gho != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (bus.clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_pend) state_nxt = ADD;
            ADD:  if (idx == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pick_pel = 1'b0;
        pick_pow = 1'b0;
        pick_gho = 1'b0;
        if (state == IDLE) begin
            if (pend_gho != '0)      pick_gho = 1'b1;
            else if (pend_pow != '0) pick_pow = 1'b1;
            else if (pend_pel != '0) pick_pel = 1'b1;
        end
        pick_any = pick_pel | pick_pow | pick_gho;
        bus.busy = (state != IDLE) | any_pend;
    end

    // Ghost value doubles along the chain; the fourth step caps at 1600.
    always_comb begin
        addend_sel = PELLET_PTS;
        if (pick_gho) begin
            case (mult)
                2'd0:    addend_sel = 16'h0200;
                2'd1:    addend_sel = 16'h0400;
                2'd2:    addend_sel = 16'h0800;
                default: addend_sel = 16'h1600;
            endcase
        end else if (pick_pow) begin
            addend_sel = POWER_PTS;
        end
    end

    always_comb begin
        dsum     = {1'b0, acc[3:0]} + {1'b0, addend[3:0]} + {4'b0, carry};
        dsum_adj = dsum - 5'd10;
        dcarry   = (dsum > 5'd9);
        dig      = dcarry ? dsum_adj[3:0] : dsum[3:0];
    end

    // acc and addend shift right one digit per cycle, so digit 0 is always in [3:0]
    // and the finished sum ends up back in acc after four shifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q  <= '0;
            sat      <= 1'b0;
            mult     <= '0;
            pend_pel <= '0;
            pend_pow <= '0;
            pend_gho <= '0;
            acc      <= '0;
            addend   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
        end else if (bus.clr) begin
            score_q  <= '0;
            sat      <= 1'b0;
            mult     <= '0;
            pend_pel <= '0;
            pend_pow <= '0;
            pend_gho <= '0;
            acc      <= '0;
            addend   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
        end else begin
            pend_pel <= pend_next(pend_pel, bus.pellet_evt, pick_pel);
            pend_pow <= pend_next(pend_pow, bus.power_evt,  pick_pow);
            pend_gho <= pend_next(pend_gho, bus.ghost_evt,  pick_gho);

            if (bus.combo_rst)
                mult <= '0;
            else if (pick_gho && mult != 2'd3)
                mult <= mult + 2'd1;

            if (pick_any) begin
                acc    <= score_q;
                addend <= addend_sel;
                idx    <= '0;
                carry  <= 1'b0;
            end else if (state == ADD) begin
                acc    <= {dig, acc[15:4]};
                addend <= {4'h0, addend[15:4]};
                carry  <= dcarry;
                idx    <= idx + 2'd1;
                // Once clipped, awards drain without touching the held 9999.
                if (idx == 2'd3 && !sat) begin
                    if (dcarry) begin
                        score_q <= 16'h9999;
                        sat     <= 1'b1;
                    end else begin
                        score_q <= {dig, acc[15:4]};
                    end
                end
            end
        end
    end

    assign bus.score      = score_q;
    assign bus.ghost_mult = mult;
    assign bus.saturated  = sat;
endmodule

// File: tb/tb_score_bcd_keeper.sv
// Directed bench for score_bcd_keeper (power award overridden to 5000 to reach the clip).
module tb_score_bcd_keeper;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [15:0] prev;
    logic [15:0] gexp [5];
    logic [1:0]  mexp [5];

    score_bcd_keeper_if bus();

    score_bcd_keeper #(
        .PELLET_PTS(16'h0010),
        .POWER_PTS (16'h5000),
        .PEND_W    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int d = 0; d < 4; d++) begin
            s = {1'b0, a[d*4 +: 4]} + {1'b0, b[d*4 +: 4]} + {4'b0, c};
            c = (s > 5'd9);
            if (c) s = s - 5'd10;
            r[d*4 +: 4] = s[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and require the score to hold or step by exactly one pellet.
    task automatic tick_step();
        logic [15:0] nxt;
        tick();
        nxt = bcd_add(prev, 16'h0010);
        total++;
        assert (bus.score === prev || bus.score === nxt) else begin
            bad++;
            $error("FAIL step: got %h expected %h or %h", bus.score, prev, nxt);
        end
        prev = bus.score;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {15'b0, bus.busy}, 16'h0000);
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        gexp  = '{16'h0200, 16'h0600, 16'h1400, 16'h3000, 16'h4600};
        mexp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst            = 1'b0;
        bus.clr        = 1'b0;
        bus.pellet_evt = 1'b0;
        bus.power_evt  = 1'b0;
        bus.ghost_evt  = 1'b0;
        bus.combo_rst  = 1'b0;
        tick();
        tick();
        chk("rst_score", bus.score, 16'h0000);
        chk("rst_mult",  {14'b0, bus.ghost_mult}, 16'h0000);
        chk("rst_busy",  {15'b0, bus.busy}, 16'h0000);
        chk("rst_sat",   {15'b0, bus.saturated}, 16'h0000);
        rst = 1'b1;
        tick();

        // Single pellet: visible only at E+5, busy gone right after.
        bus.pellet_evt = 1'b1;
        tick();
        bus.pellet_evt = 1'b0;
        chk("pel_busy_e0", {15'b0, bus.busy}, 16'h0001);
        repeat (3) tick();
        chk("pel_e3", bus.score, 16'h0000);
        tick();
        chk("pel_e4", bus.score, 16'h0000);
        chk("pel_busy_e4", {15'b0, bus.busy}, 16'h0001);
        tick();
        chk("pel_e5", bus.score, 16'h0010);
        chk("pel_busy_e5", {15'b0, bus.busy}, 16'h0000);

        // Ten back-to-back pellets.
        do_clr();
        chk("clr_score", bus.score, 16'h0000);
        prev = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            bus.pellet_evt = 1'b1;
            tick_step();
        end
        bus.pellet_evt = 1'b0;
        repeat (40) tick_step();
        chk("burst_e49", bus.score, 16'h0090);
        tick_step();
        chk("burst_e50", bus.score, 16'h0100);
        chk("burst_idle", {15'b0, bus.busy}, 16'h0000);

        // Twenty back-to-back pellets: pending clips at 15, one pulse lost.
        do_clr();
        for (int i = 0; i < 20; i++) begin
            bus.pellet_evt = 1'b1;
            tick();
        end
        bus.pellet_evt = 1'b0;
        wait_idle("pend_sat_idle", 200);
        chk("pend_sat_score", bus.score, 16'h0190);

        // Ghost chain.
        do_clr();
        for (int g = 0; g < 5; g++) begin
            bus.ghost_evt = 1'b1;
            tick();
            bus.ghost_evt = 1'b0;
            repeat (7) tick();
            chk("ghost_score", bus.score, gexp[g]);
            chk("ghost_mult", {14'b0, bus.ghost_mult}, {14'b0, mexp[g]});
        end
        bus.combo_rst = 1'b1;
        tick();
        bus.combo_rst = 1'b0;
        chk("combo_mult", {14'b0, bus.ghost_mult}, 16'h0000);
        bus.ghost_evt = 1'b1;
        tick();
        bus.ghost_evt = 1'b0;
        repeat (7) tick();
        chk("combo_score", bus.score, 16'h4800);
        chk("combo_mult1", {14'b0, bus.ghost_mult}, 16'h0001);

        // Reset mid-run with a ghost award queued.
        bus.ghost_evt = 1'b1;
        tick();
        bus.ghost_evt = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("arst_score", bus.score, 16'h0000);
        chk("arst_mult",  {14'b0, bus.ghost_mult}, 16'h0000);
        chk("arst_busy",  {15'b0, bus.busy}, 16'h0000);
        chk("arst_sat",   {15'b0, bus.saturated}, 16'h0000);
        repeat (2) tick();
        rst = 1'b1;
        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("arst_release", bus.score, 16'h0000);
        end
        chk("arst_rel_busy", {15'b0, bus.busy}, 16'h0000);

        // Clip at 9999.
        do_clr();
        bus.power_evt = 1'b1;
        tick();
        bus.power_evt = 1'b0;
        repeat (7) tick();
        chk("pow1_score", bus.score, 16'h5000);
        chk("pow1_sat", {15'b0, bus.saturated}, 16'h0000);
        bus.power_evt = 1'b1;
        tick();
        bus.power_evt = 1'b0;
        repeat (7) tick();
        chk("pow2_score", bus.score, 16'h9999);
        chk("pow2_sat", {15'b0, bus.saturated}, 16'h0001);
        bus.pellet_evt = 1'b1;
        tick();
        bus.pellet_evt = 1'b0;
        chk("satpel_busy", {15'b0, bus.busy}, 16'h0001);
        repeat (7) tick();
        chk("satpel_score", bus.score, 16'h9999);
        chk("satpel_idle", {15'b0, bus.busy}, 16'h0000);
        chk("satpel_sat", {15'b0, bus.saturated}, 16'h0001);
        do_clr();
        chk("satclr_score", bus.score, 16'h0000);
        chk("satclr_sat", {15'b0, bus.saturated}, 16'h0000);

        // Async reset during digit 2 of an addition.
        bus.pellet_evt = 1'b1;
        tick();
        bus.pellet_evt = 1'b0;
        repeat (7) tick();
        chk("pre_arst_score", bus.score, 16'h0010);
        bus.pellet_evt = 1'b1;
        tick();
        bus.pellet_evt = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        chk("dig2_arst_score", bus.score, 16'h0000);
        chk("dig2_arst_busy", {15'b0, bus.busy}, 16'h0000);
        #3 rst = 1'b1;
        repeat (10) tick();
        chk("dig2_no_commit", bus.score, 16'h0000);
        chk("dig2_idle", {15'b0, bus.busy}, 16'h0000);

        // clr drops a same-cycle event.
        bus.clr        = 1'b1;
        bus.pellet_evt = 1'b1;
        tick();
        bus.clr        = 1'b0;
        bus.pellet_evt = 1'b0;
        chk("clrevt_busy", {15'b0, bus.busy}, 16'h0000);
        repeat (6) tick();
        chk("clrevt_score", bus.score, 16'h0000);
        chk("clrevt_busy_late", {15'b0, bus.busy}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
